// File: rtl/rv32_pipe_pkg.sv
// rv32_pipe_pkg: shared constants, ALU ops and the
// pipeline register bundles of the five-stage rv32 core.
package rv32_pipe_pkg;

  localparam int XLEN       = 32;
  localparam int IMEM_WORDS = 64;
  localparam int DMEM_WORDS = 32;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_NONE,
    FWD_EXMEM,
    FWD_MEMWB
  } fwd_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            halt;
  } if_id_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] imm;
    alu_op_e         alu_op;
    logic            alu_imm;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            halt;
  } id_ex_t;

  typedef struct packed {
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] store_data;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            halt;
  } ex_mem_t;

  typedef struct packed {
    logic [XLEN-1:0] wb_data;
    logic [4:0]      rd;
    logic            reg_write;
  } mem_wb_t;

  function automatic logic [XLEN-1:0] alu_eval(
    input alu_op_e         op,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b
  );
    logic [XLEN-1:0] r;
    unique case (op)
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_SLT: r = {{(XLEN-1){1'b0}},
                    $signed(a) < $signed(b)};
      default: r = a + b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rv32_hazard_unit.sv
// rv32_hazard_unit: EX operand forwarding selects,
// load-use stall and taken-branch flush.
module rv32_hazard_unit
  import rv32_pipe_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use1,
  input  logic       id_use2,
  input  logic [4:0] ex_rs1,
  input  logic [4:0] ex_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  input  logic [4:0] exmem_rd,
  input  logic       exmem_we,
  input  logic [4:0] memwb_rd,
  input  logic       memwb_we,
  input  logic       branch_taken,
  output fwd_e       fwd_a,
  output fwd_e       fwd_b,
  output logic       stall,
  output logic       flush
);
  function automatic fwd_e sel(input logic [4:0] rs);
    if (exmem_we && exmem_rd != 5'd0 && exmem_rd == rs)
      return FWD_EXMEM;
    if (memwb_we && memwb_rd != 5'd0 && memwb_rd == rs)
      return FWD_MEMWB;
    return FWD_NONE;
  endfunction

  logic hit1, hit2;

  assign fwd_a = sel(ex_rs1);
  assign fwd_b = sel(ex_rs2);

  assign hit1  = id_use1 && id_rs1 == ex_rd;
  assign hit2  = id_use2 && id_rs2 == ex_rd;
  assign stall = ex_mem_read && ex_rd != 5'd0
              && (hit1 || hit2);
  assign flush = branch_taken;
endmodule

// File: rtl/rv32_pipe_core_mem.sv
// rv32 storage blocks: instruction memory, data memory
// and the two-read, one-write register file.
module rv32_imem
  import rv32_pipe_pkg::*;
#(
  parameter int WORDS = IMEM_WORDS
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(WORDS)-1:0] waddr,
  input  logic [31:0]              wdata,
  input  logic [$clog2(WORDS)-1:0] addr,
  output logic [31:0]              instr
);
  logic [31:0] memory [0:WORDS-1];

  always_ff @(posedge clk) begin
    if (we) memory[waddr] <= wdata;
  end

  assign instr = memory[addr];
endmodule

module rv32_dmem
  import rv32_pipe_pkg::*;
#(
  parameter int WORDS = DMEM_WORDS
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(WORDS)-1:0] addr,
  input  logic [XLEN-1:0]          wdata,
  output logic [XLEN-1:0]          rdata
);
  logic [XLEN-1:0] memory [0:WORDS-1];

  always_ff @(posedge clk) begin
    if (we) memory[addr] <= wdata;
  end

  assign rdata = memory[addr];
endmodule

module rv32_reg_file
  import rv32_pipe_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] wdata
);
  logic [XLEN-1:0] registers [0:31];
  logic            wr;

  assign wr = we && (rd != 5'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        registers[i] <= '0;
      end
    end else if (wr) begin
      registers[rd] <= wdata;
    end
  end

  // write-first: ID sees the value WB is writing this cycle
  assign rdata1 = (wr && rd == rs1) ? wdata : registers[rs1];
  assign rdata2 = (wr && rd == rs2) ? wdata : registers[rs2];
endmodule

// File: rtl/rv32_pipe_core.sv
// rv32_pipe_core: five-stage in-order RV32I-subset core
// running from internal memories until a halt word retires.
module rv32_pipe_core
  import rv32_pipe_pkg::*;
(
  input  logic clk,
  input  logic reset,
  output logic end_program
);
  logic [XLEN-1:0] pc;
  logic [31:0]     if_instr;
  logic            if_halt;
  if_id_t          if_id;
  id_ex_t          id_ex;
  id_ex_t          id_ctl;
  ex_mem_t         ex_mem;
  ex_mem_t         ex_nx;
  mem_wb_t         mem_wb;
  logic            stall, flush;
  fwd_e            fwd_a, fwd_b;
  logic [XLEN-1:0] br_target;
  logic            br_taken;

  // ---------------- IF ----------------
  rv32_imem imem (
    .clk   (clk),
    .we    (1'b0),
    .waddr (6'd0),
    .wdata (32'd0),
    .addr  (pc[7:2]),
    .instr (if_instr)
  );

  assign if_halt = (if_instr == HALT_WORD);

  // a taken branch outranks a younger fetched halt
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= '0;
    end else if (flush) begin
      pc <= br_target;
    end else if (!stall && !if_halt) begin
      pc <= pc + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_id <= '0;
    end else if (flush) begin
      if_id <= '0;
    end else if (!stall) begin
      if_id.pc    <= pc;
      if_id.instr <= if_instr;
      if_id.halt  <= if_halt;
    end
  end

  // ---------------- ID ----------------
  logic [31:0]     ins;
  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  logic [4:0]      id_rs1, id_rs2, id_rd;
  logic [XLEN-1:0] rdata1, rdata2;
  logic [XLEN-1:0] imm_i, imm_s, imm_b;
  logic            dec_r, dec_addi, dec_lw;
  logic            dec_sw, dec_beq;
  logic            r_ok, use1, use2;
  alu_op_e         r_op;

  assign ins    = if_id.instr;
  assign opc    = ins[6:0];
  assign id_rd  = ins[11:7];
  assign f3     = ins[14:12];
  assign id_rs1 = ins[19:15];
  assign id_rs2 = ins[24:20];
  assign f7     = ins[31:25];

  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{19{ins[31]}}, ins[31], ins[7],
                  ins[30:25], ins[11:8], 1'b0};

  always_comb begin
    r_op = ALU_ADD;
    r_ok = 1'b0;
    if (f7 == F7_SUB) begin
      r_op = ALU_SUB;
      r_ok = (f3 == F3_ADD);
    end else if (f7 == F7_BASE) begin
      r_ok = 1'b1;
      case (f3)
        F3_ADD:  r_op = ALU_ADD;
        F3_AND:  r_op = ALU_AND;
        F3_OR:   r_op = ALU_OR;
        F3_SLT:  r_op = ALU_SLT;
        default: r_ok = 1'b0;
      endcase
    end
  end

  assign dec_r    = opc == OP_R    && r_ok;
  assign dec_addi = opc == OP_ADDI && f3 == F3_ADD;
  assign dec_lw   = opc == OP_LW   && f3 == F3_W;
  assign dec_sw   = opc == OP_SW   && f3 == F3_W;
  assign dec_beq  = opc == OP_BEQ  && f3 == F3_BEQ;

  rv32_reg_file reg_file (
    .clk    (clk),
    .reset  (reset),
    .rs1    (id_rs1),
    .rs2    (id_rs2),
    .rdata1 (rdata1),
    .rdata2 (rdata2),
    .we     (mem_wb.reg_write),
    .rd     (mem_wb.rd),
    .wdata  (mem_wb.wb_data)
  );

  always_comb begin
    id_ctl      = '0;
    use1        = 1'b0;
    use2        = 1'b0;
    id_ctl.pc   = if_id.pc;
    id_ctl.rs1  = id_rs1;
    id_ctl.rs2  = id_rs2;
    id_ctl.rd   = id_rd;
    id_ctl.a    = rdata1;
    id_ctl.b    = rdata2;
    id_ctl.halt = if_id.halt;
    unique case (1'b1)
      dec_r: begin
        use1             = 1'b1;
        use2             = 1'b1;
        id_ctl.alu_op    = r_op;
        id_ctl.reg_write = 1'b1;
      end
      dec_addi: begin
        use1             = 1'b1;
        id_ctl.imm       = imm_i;
        id_ctl.alu_imm   = 1'b1;
        id_ctl.reg_write = 1'b1;
      end
      dec_lw: begin
        use1             = 1'b1;
        id_ctl.imm       = imm_i;
        id_ctl.alu_imm   = 1'b1;
        id_ctl.reg_write = 1'b1;
        id_ctl.mem_read  = 1'b1;
      end
      dec_sw: begin
        use1             = 1'b1;
        use2             = 1'b1;
        id_ctl.imm       = imm_s;
        id_ctl.alu_imm   = 1'b1;
        id_ctl.mem_write = 1'b1;
      end
      dec_beq: begin
        use1          = 1'b1;
        use2          = 1'b1;
        id_ctl.imm    = imm_b;
        id_ctl.branch = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_ex <= '0;
    end else if (flush || stall) begin
      id_ex <= '0;
    end else begin
      id_ex <= id_ctl;
    end
  end

  rv32_hazard_unit hazard (
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use1      (use1),
    .id_use2      (use2),
    .ex_rs1       (id_ex.rs1),
    .ex_rs2       (id_ex.rs2),
    .ex_rd        (id_ex.rd),
    .ex_mem_read  (id_ex.mem_read),
    .exmem_rd     (ex_mem.rd),
    .exmem_we     (ex_mem.reg_write),
    .memwb_rd     (mem_wb.rd),
    .memwb_we     (mem_wb.reg_write),
    .branch_taken (br_taken),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .stall        (stall),
    .flush        (flush)
  );

  // ---------------- EX ----------------
  logic [XLEN-1:0] op_a, op_b;

  always_comb begin
    unique case (fwd_a)
      FWD_EXMEM: op_a = ex_mem.alu_result;
      FWD_MEMWB: op_a = mem_wb.wb_data;
      default:   op_a = id_ex.a;
    endcase
  end

  always_comb begin
    unique case (fwd_b)
      FWD_EXMEM: op_b = ex_mem.alu_result;
      FWD_MEMWB: op_b = mem_wb.wb_data;
      default:   op_b = id_ex.b;
    endcase
  end

  assign br_taken  = id_ex.branch && (op_a == op_b);
  assign br_target = id_ex.pc + id_ex.imm;

  always_comb begin
    ex_nx            = '0;
    ex_nx.alu_result = alu_eval(id_ex.alu_op, op_a,
                         id_ex.alu_imm ? id_ex.imm : op_b);
    ex_nx.store_data = op_b;
    ex_nx.rd         = id_ex.rd;
    ex_nx.reg_write  = id_ex.reg_write;
    ex_nx.mem_read   = id_ex.mem_read;
    ex_nx.mem_write  = id_ex.mem_write;
    ex_nx.halt       = id_ex.halt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_mem <= '0;
    end else begin
      ex_mem <= ex_nx;
    end
  end

  // ---------------- MEM ----------------
  logic [XLEN-1:0] ld_data;

  rv32_dmem dmem (
    .clk   (clk),
    .we    (ex_mem.mem_write),
    .addr  (ex_mem.alu_result[6:2]),
    .wdata (ex_mem.store_data),
    .rdata (ld_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_wb <= '0;
    end else begin
      mem_wb.wb_data   <= ex_mem.mem_read ? ld_data
                                          : ex_mem.alu_result;
      mem_wb.rd        <= ex_mem.rd;
      mem_wb.reg_write <= ex_mem.reg_write;
    end
  end

  // ---------------- WB ----------------
  // rises as the halt marker lands in MEM/WB
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      end_program <= 1'b0;
    end else if (ex_mem.halt) begin
      end_program <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rv32_pipe_core.sv
// tb_rv32_pipe_core: directed programs with a table of
// expected register/dmem values plus reset and latency cases.
module tb_rv32_pipe_core;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic clk;
  logic reset;
  logic end_program;

  int nvec = 0;
  int nmis = 0;

  rv32_pipe_core dut (
    .clk         (clk),
    .reset       (reset),
    .end_program (end_program)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          prog;
    logic [31:0] d0;
    bit          is_mem;
    int          idx;
    logic [31:0] exp;
  } vec_t;

  logic [31:0] progs [0:5][0:7];
  vec_t        vecs [0:23];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic load(input int p, input logic [31:0] d0);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 64; i++)
      dut.imem.memory[i] <= (i < 8) ? progs[p][i] : HALT;
    for (int i = 0; i < 32; i++)
      dut.dmem.memory[i] <= (i == 0) ? d0 : 32'd0;
    @(negedge clk);
  endtask

  task automatic run(input string name, output int cyc);
    bit done;
    cyc  = 0;
    done = 1'b0;
    reset = 1'b1;
    while (!done && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
      if (end_program) done = 1'b1;
    end
    check({name, "_end"}, {31'd0, done}, 32'd1);
  endtask

  function automatic vec_t mk(int p, logic [31:0] d,
                              bit m, int i,
                              logic [31:0] e);
    vec_t v;
    v.prog = p; v.d0 = d; v.is_mem = m;
    v.idx = i;  v.exp = e;
    return v;
  endfunction

  initial begin
    int          cyc;
    int          last_p;
    logic [31:0] last_d;
    logic [31:0] act;

    for (int p = 0; p < 6; p++)
      for (int i = 0; i < 8; i++) progs[p][i] = HALT;
    // load-use program
    progs[0][0] = 32'h00002103;
    progs[0][1] = 32'h00110213;
    progs[0][2] = 32'h00600413;
    progs[0][3] = 32'h002404B3;
    // sub / sw / lw
    progs[1][0] = 32'h00700093;
    progs[1][1] = 32'h00300113;
    progs[1][2] = 32'h402081B3;
    progs[1][3] = 32'h00302423;
    progs[1][4] = 32'h00802283;
    // taken beq skips one instruction
    progs[2][0] = 32'h00100093;
    progs[2][1] = 32'h00108463;
    progs[2][2] = 32'h00900313;
    progs[2][3] = 32'h00200393;
    // x0 write, unsupported encodings as NOPs
    progs[3][0] = 32'h00700093;
    progs[3][1] = 32'h00300113;
    progs[3][2] = 32'h00500013;
    progs[3][3] = 32'h0020C1B3;
    progs[3][4] = 32'h4020F1B3;
    progs[3][5] = 32'h12345678;
    // and / or / slt with a negative operand
    progs[4][0] = 32'hFFD00093;
    progs[4][1] = 32'h00500113;
    progs[4][2] = 32'h0020F1B3;
    progs[4][3] = 32'h0020E233;
    progs[4][4] = 32'h0020A2B3;
    progs[4][5] = 32'h00112333;
    // progs[5] is halt only

    vecs[0]  = mk(0, 0, 0, 2, 0);
    vecs[1]  = mk(0, 0, 0, 4, 1);
    vecs[2]  = mk(0, 0, 0, 8, 6);
    vecs[3]  = mk(0, 0, 0, 9, 6);
    vecs[4]  = mk(0, 5, 0, 2, 5);
    vecs[5]  = mk(0, 5, 0, 4, 6);
    vecs[6]  = mk(0, 5, 0, 8, 6);
    vecs[7]  = mk(0, 5, 0, 9, 11);
    vecs[8]  = mk(1, 0, 0, 3, 4);
    vecs[9]  = mk(1, 0, 1, 2, 4);
    vecs[10] = mk(1, 0, 0, 5, 4);
    vecs[11] = mk(2, 0, 0, 1, 1);
    vecs[12] = mk(2, 0, 0, 6, 0);
    vecs[13] = mk(2, 0, 0, 7, 2);
    vecs[14] = mk(3, 0, 0, 0, 0);
    vecs[15] = mk(3, 0, 0, 1, 7);
    vecs[16] = mk(3, 0, 0, 3, 0);
    vecs[17] = mk(4, 0, 0, 1, 32'hFFFF_FFFD);
    vecs[18] = mk(4, 0, 0, 2, 5);
    vecs[19] = mk(4, 0, 0, 3, 5);
    vecs[20] = mk(4, 0, 0, 4, 32'hFFFF_FFFD);
    vecs[21] = mk(4, 0, 0, 5, 1);
    vecs[22] = mk(4, 0, 0, 6, 0);
    vecs[23] = mk(1, 0, 0, 4, 0);

    reset = 1'b1;
    #2;
    reset = 1'b0;

    // reset state
    load(5, 0);
    check("rst_end", {31'd0, end_program}, 0);
    check("rst_pc", dut.pc, 0);
    for (int r = 0; r < 32; r++)
      check($sformatf("rst_x%0d", r),
            dut.reg_file.registers[r], 0);

    // halt at pc 0 reaches WB after four edges
    run("lat", cyc);
    check("halt_latency", cyc, 4);
    repeat (3) @(posedge clk);
    #1;
    check("end_sticky", {31'd0, end_program}, 1);
    check("halt_pc", dut.pc, 0);

    last_p = -1;
    last_d = '0;
    for (int i = 0; i < 24; i++) begin
      if (vecs[i].prog != last_p || vecs[i].d0 != last_d) begin
        load(vecs[i].prog, vecs[i].d0);
        run($sformatf("prog%0d", vecs[i].prog), cyc);
        repeat (3) @(posedge clk);
        #1;
        last_p = vecs[i].prog;
        last_d = vecs[i].d0;
      end
      act = vecs[i].is_mem
          ? dut.dmem.memory[vecs[i].idx]
          : dut.reg_file.registers[vecs[i].idx];
      check($sformatf("v%0d_%s%0d", i,
                      vecs[i].is_mem ? "dmem" : "x",
                      vecs[i].idx), act, vecs[i].exp);
    end

    // base run leaves every untouched register at zero
    load(0, 0);
    run("base", cyc);
    for (int r = 0; r < 32; r++)
      if (r != 2 && r != 4 && r != 8 && r != 9)
        check($sformatf("base_x%0d", r),
              dut.reg_file.registers[r], 0);

    // reset mid-program, then rerun from scratch
    load(0, 5);
    reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("mid_x2_before", dut.reg_file.registers[2], 5);
    reset = 1'b0;
    #1;
    check("mid_pc", dut.pc, 0);
    check("mid_end", {31'd0, end_program}, 0);
    check("mid_x2", dut.reg_file.registers[2], 0);
    check("mid_dmem0", dut.dmem.memory[0], 5);
    @(negedge clk);
    run("rerun", cyc);
    check("rerun_x2", dut.reg_file.registers[2], 5);
    check("rerun_x4", dut.reg_file.registers[4], 6);
    check("rerun_x8", dut.reg_file.registers[8], 6);
    check("rerun_x9", dut.reg_file.registers[9], 11);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule
